// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI mode-0 shift engine.
// Optional feature macro (consumed by spi_shift_engine): SPI_LSB_FIRST_EN.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } spi_state_t;

  localparam int SPI_DATA_W_DEF = 8;

endpackage

// File: rtl/spi_edge_detect.sv
// Registers the divided SPI clock in the PCLK domain and flags its edges.
// Both edges cannot be flagged together because they depend on opposite sclk_in levels.
module spi_edge_detect (
  input  logic PCLK,
  input  logic PRESET,
  input  logic sclk_in,
  output logic rise,
  output logic fall,
  output logic sclk_q
);

  logic sclk_d;

  // Next value of the delayed copy is just the current input level.
  always_comb begin
    sclk_d = sclk_in;
  end

  // One-cycle delayed copy of the divider output.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      sclk_q <= 1'b0;
    end else begin
      sclk_q <= sclk_d;
    end
  end

  assign rise = sclk_in & ~sclk_q;
  assign fall = ~sclk_in & sclk_q;

endmodule

// File: rtl/spi_shift_engine.sv
// SPI mode-0 (CPOL=0, CPHA=0) master shift engine driven by an external clock divider.
// Build option: define SPI_LSB_FIRST_EN to shift LSB first on both MOSI and MISO;
// otherwise MSB first. Only the shift direction changes; timing is identical.
//
// state | meaning
// IDLE  | tx_ready high, waiting for a word; CS_n high
// SETUP | CS_n low, first bit on MOSI, waiting for a divider fall so SCLK starts low
// SHIFT | capture MISO on each rise, present next MOSI bit on each fall
// HOLD  | last bit captured; release CS_n and publish rx_data on the next fall
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W_DEF
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              sclk_in,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic              CS_n
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

`ifdef SPI_LSB_FIRST_EN
  localparam int FIRST_IDX = 0;
  localparam int NEXT_IDX  = 1;
`else
  localparam int FIRST_IDX = DATA_W - 1;
  localparam int NEXT_IDX  = DATA_W - 2;
`endif

  logic rise;
  logic fall;
  logic sclk_q;
  logic edge_any;

  spi_state_t        state_q, state_d;
  logic              cs_n_q, cs_n_d;
  logic              mosi_q, mosi_d;
  logic              sclk_o_q, sclk_o_d;
  logic              tx_ready_q, tx_ready_d;
  logic              rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [DATA_W-1:0] shift_tx_q, shift_tx_d;
  logic [DATA_W-1:0] shift_rx_q, shift_rx_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              gate;

  spi_edge_detect u_edge (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .sclk_in (sclk_in),
    .rise    (rise),
    .fall    (fall),
    .sclk_q  (sclk_q)
  );

  // Any divider transition; inside SHIFT a transition that is not a rise is a fall.
  assign edge_any = sclk_in ^ sclk_q;

  // Next-state, shift datapath and framing outputs.
  always_comb begin
    state_d    = state_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    tx_ready_d = 1'b0;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    shift_tx_d = shift_tx_q;
    shift_rx_d = shift_rx_q;
    bit_cnt_d  = bit_cnt_q;

    case (state_q)
      IDLE: begin
        tx_ready_d = 1'b1;
        if (tx_valid && tx_ready_q) begin
          shift_tx_d = tx_data;
          shift_rx_d = '0;
          mosi_d     = tx_data[FIRST_IDX];
          cs_n_d     = 1'b0;
          bit_cnt_d  = '0;
          tx_ready_d = 1'b0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (fall) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (edge_any) begin
          if (rise) begin
`ifdef SPI_LSB_FIRST_EN
            shift_rx_d = {MISO, shift_rx_q[DATA_W-1:1]};
`else
            shift_rx_d = {shift_rx_q[DATA_W-2:0], MISO};
`endif
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == LAST_BIT) begin
              state_d = HOLD;
            end
          end else begin
`ifdef SPI_LSB_FIRST_EN
            shift_tx_d = {1'b0, shift_tx_q[DATA_W-1:1]};
`else
            shift_tx_d = {shift_tx_q[DATA_W-2:0], 1'b0};
`endif
            mosi_d = shift_tx_q[NEXT_IDX];
          end
        end
      end
      HOLD: begin
        if (fall) begin
          cs_n_d     = 1'b1;
          rx_data_d  = shift_rx_q;
          rx_valid_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
      end
    endcase

    gate     = (state_q == SHIFT) || (state_q == HOLD);
    sclk_o_d = gate & sclk_in;
  end

  // State and output registers; reset drops CS_n and SCLK on the very next edge.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= IDLE;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      sclk_o_q   <= 1'b0;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      shift_tx_q <= '0;
      shift_rx_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      sclk_o_q   <= sclk_o_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      shift_tx_q <= shift_tx_d;
      shift_rx_q <= shift_rx_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign busy     = (state_q != IDLE);
  assign SCLK     = sclk_o_q;
  assign MOSI     = mosi_q;
  assign CS_n     = cs_n_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine: divider model, loopback/tied MISO, bus monitor.
module tb_spi_shift_engine;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       sclk_in = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] tx_data = 8'h00;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic       SCLK;
  logic       MOSI;
  logic       MISO;
  logic       CS_n;

  logic miso_loop = 1'b1;
  logic miso_fix  = 1'b0;
  assign MISO = miso_loop ? MOSI : miso_fix;

  int n_vec = 0;
  int n_err = 0;

  spi_shift_engine #(.DATA_W(8)) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .sclk_in  (sclk_in),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .busy     (busy),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .CS_n     (CS_n)
  );

  always #5 PCLK = ~PCLK;

  // Divider model: sclk_in toggles every h_div PCLK cycles.
  int h_div = 4;
  int div_cnt = 0;
  always @(negedge PCLK) begin
    if (div_cnt >= h_div - 1) begin
      div_cnt = 0;
      sclk_in = ~sclk_in;
    end else begin
      div_cnt = div_cnt + 1;
    end
  end

  // Bus monitor, sampled mid-cycle.
  int          rise_total = 0;
  int          rxv_total = 0;
  int          cs_low_run = 0;
  int          cs_high_run = 0;
  int          last_cs_len = 0;
  int          last_gap = 0;
  int          cyc_since_rise = 0;
  int          last_period = 0;
  logic        sclk_prev = 1'b0;
  logic        cs_prev = 1'b1;
  logic [31:0] mosi_hist = '0;
  always @(negedge PCLK) begin
    cyc_since_rise = cyc_since_rise + 1;
    if (SCLK && !sclk_prev) begin
      if (!CS_n) begin
        rise_total = rise_total + 1;
        mosi_hist  = {mosi_hist[30:0], MOSI};
      end
      last_period    = cyc_since_rise;
      cyc_since_rise = 0;
    end
    if (CS_n && !cs_prev) begin
      last_cs_len = cs_low_run;
      cs_low_run  = 0;
    end
    if (!CS_n && cs_prev) begin
      last_gap    = cs_high_run;
      cs_high_run = 0;
    end
    if (!CS_n) cs_low_run = cs_low_run + 1;
    else       cs_high_run = cs_high_run + 1;
    if (rx_valid) rxv_total = rxv_total + 1;
    sclk_prev = SCLK;
    cs_prev   = CS_n;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_first(input logic [7:0] d);
`ifdef SPI_LSB_FIRST_EN
    return d[0];
`else
    return d[7];
`endif
  endfunction

  // Bits in wire order, first bit in the MSB position.
  function automatic logic [7:0] wire_order(input logic [7:0] d);
    logic [7:0] r;
`ifdef SPI_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[7-i] = d[i];
`else
    r = d;
`endif
    return r;
  endfunction

  // Wait for tx_ready, present a word, check CS_n and first MOSI bit one cycle after accept.
  task automatic start_xfer(input logic [7:0] d, input logic keep_valid);
    int n = 0;
    while (!tx_ready && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    check_val("tx_ready_seen", {31'b0, tx_ready}, 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge PCLK);
    check_val("cs_n_after_accept", {31'b0, CS_n}, 32'd0);
    check_val("mosi_first_bit", {31'b0, MOSI}, {31'b0, exp_first(d)});
    if (!keep_valid) tx_valid = 1'b0;
  endtask

  task automatic wait_rx(output logic [7:0] d);
    int   n = 0;
    logic ok = 1'b0;
    d = 8'h00;
    while (n < 400 && !ok) begin
      @(negedge PCLK);
      n++;
      if (rx_valid) begin
        ok = 1'b1;
        d  = rx_data;
      end
    end
    check_val("rx_valid_seen", {31'b0, ok}, 32'd1);
  endtask

  // Full transfer with monitor-based checks on rise count, pulse count and wire bits.
  task automatic full_xfer(input string tag, input logic [7:0] d, input logic [7:0] exp_rx);
    int          rise_b;
    int          rxv_b;
    logic [7:0]  got;
    rise_b = rise_total;
    rxv_b  = rxv_total;
    start_xfer(d, 1'b0);
    wait_rx(got);
    repeat (2) @(negedge PCLK);
    check_val({tag, "_rx"}, {24'b0, got}, {24'b0, exp_rx});
    check_val({tag, "_rises"}, rise_total - rise_b, 32'd8);
    check_val({tag, "_rxv_cnt"}, rxv_total - rxv_b, 32'd1);
    check_val({tag, "_mosi_bits"}, {24'b0, mosi_hist[7:0]}, {24'b0, wire_order(d)});
    // SETUP wait varies with divider phase at accept: 1..2H before the 16H of bit time.
    check_val({tag, "_cs_len_ok"},
              {31'b0, (last_cs_len >= 16 * h_div + 1) && (last_cs_len <= 19 * h_div)}, 32'd1);
  endtask

  initial begin
    logic [7:0] got;
    int         n;
    int         rise_b;
    int         rxv_b;

    // Reset values.
    PRESET = 1'b1;
    repeat (2) @(negedge PCLK);
    check_val("rst_cs_n", {31'b0, CS_n}, 32'd1);
    check_val("rst_sclk", {31'b0, SCLK}, 32'd0);
    check_val("rst_mosi", {31'b0, MOSI}, 32'd0);
    check_val("rst_tx_ready", {31'b0, tx_ready}, 32'd0);
    check_val("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    check_val("rst_rx_data", {24'b0, rx_data}, 32'd0);
    check_val("rst_busy", {31'b0, busy}, 32'd0);
    PRESET = 1'b0;
    @(negedge PCLK);
    check_val("tx_ready_after_rst", {31'b0, tx_ready}, 32'd1);

    // Loopback 0xA5 at H=4.
    full_xfer("loop_a5", 8'hA5, 8'hA5);
    check_val("idle_busy", {31'b0, busy}, 32'd0);

    // MISO tied high, zeros out.
    miso_loop = 1'b0;
    miso_fix  = 1'b1;
    full_xfer("tied1", 8'h00, 8'hFF);
    miso_loop = 1'b1;

    // Reset after the third SCLK rise.
    rise_b = rise_total;
    start_xfer(8'hC3, 1'b0);
    n = 0;
    while ((rise_total - rise_b) < 3 && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    check_val("mid_rst_reached_3", {31'b0, (rise_total - rise_b) >= 3}, 32'd1);
    PRESET = 1'b1;
    @(negedge PCLK);
    check_val("mid_rst_cs_n", {31'b0, CS_n}, 32'd1);
    check_val("mid_rst_sclk", {31'b0, SCLK}, 32'd0);
    check_val("mid_rst_busy", {31'b0, busy}, 32'd0);
    check_val("mid_rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    rxv_b  = rxv_total;
    PRESET = 1'b0;
    repeat (20) @(negedge PCLK);
    check_val("mid_rst_no_rxv", rxv_total - rxv_b, 32'd0);
    full_xfer("after_rst_3c", 8'h3C, 8'h3C);

    // tx_valid held high across two words.
    start_xfer(8'h11, 1'b1);
    tx_data = 8'h22;
    wait_rx(got);
    check_val("hold_first_rx", {24'b0, got}, 32'h11);
    wait_rx(got);
    tx_valid = 1'b0;
    check_val("hold_second_rx", {24'b0, got}, 32'h22);
    check_val("hold_gap_ok", {31'b0, last_gap >= 1}, 32'd1);
    repeat (4) @(negedge PCLK);
    check_val("hold_idle_after", {31'b0, busy}, 32'd0);

    // Maximum-rate divider.
    h_div = 1;
    repeat (4) @(negedge PCLK);
    full_xfer("h1_5a", 8'h5A, 8'h5A);
    check_val("h1_sclk_period", last_period, 32'd2);

    // Single set bit exposes the shift direction.
    h_div = 4;
    repeat (10) @(negedge PCLK);
    full_xfer("one_01", 8'h01, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

endmodule
